miner_work_scheduler: RTL and testbench

Work scheduler for a bank of `fpgaminer_top` cores.
- Accepts one job (midstate, work_data, nonce base) per handshake and splits the nonce range evenly across NUM_CORES cores.
- Sequences core reset, the run window and a post-run drain window.
- Arbitrates the cores' golden-nonce pulses into one buffered result stream for the host interface.
- Sits between the host/UART work interface and the miner cores, all on `hash_clk`.

---
 rtl/miner_work_scheduler_if.sv | 22 ++
 rtl/miner_work_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_miner_work_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_work_scheduler_if.sv
// Host-side work and result channels of the miner work scheduler.
interface miner_work_scheduler_if;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  work_nonce_base;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [2:0]   res_core;

  modport master (
    output work_valid, work_midstate, work_data, work_nonce_base, res_ready,
    input  work_ready, res_valid, res_nonce, res_core
  );

  modport slave (
    input  work_valid, work_midstate, work_data, work_nonce_base, res_ready,
    output work_ready, res_valid, res_nonce, res_core
  );
endinterface

// File: rtl/miner_work_scheduler.sv
// Job sequencing, per-core golden capture and round-robin result FIFO
// for a bank of fpgaminer cores.

// Per-core golden capture: one pending flag plus the held nonce.
module mws_core_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic        pulse,
  input  logic [31:0] nonce,
  input  logic        grant,
  output logic        pending,
  output logic [31:0] hold,
  output logic        drop
);
  // A pulse that finds the slot occupied is lost, even if it is granted now.
  assign drop = active & pulse & pending;

  // Capture a new nonce into a free slot; the arbiter grant frees it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= 1'b0;
      hold    <= '0;
    end else if (grant) begin
      pending <= 1'b0;
    end else if (active && pulse && !pending) begin
      pending <= 1'b1;
      hold    <= nonce;
    end
  end
endmodule

module miner_work_scheduler #(
  parameter int NUM_CORES    = 4,
  parameter int SPAN_LOG2    = 30,
  parameter int DRAIN_CYCLES = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        hash_clk,
  input  logic                        reset,
  miner_work_scheduler_if.slave       wif,
  input  logic                        abort,
  output logic [255:0]                core_midstate,
  output logic [95:0]                 core_work_data,
  output logic [NUM_CORES-1:0][31:0]  core_nonce_min,
  output logic [NUM_CORES-1:0]        core_reset,
  input  logic [NUM_CORES-1:0]        core_golden_valid,
  input  logic [NUM_CORES-1:0][31:0]  core_golden_nonce,
  output logic                        busy,
  output logic                        exhausted,
  output logic                        overflow
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int CW = (SPAN_LOG2 > DW) ? SPAN_LOG2 : DW;
  localparam logic [CW-1:0] RUN_LAST   = (CW'(1) << SPAN_LOG2) - CW'(1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [2:0]  core;
    logic [31:0] nonce;
  } res_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ready_q, exh_nxt, hs, active;

  assign hs         = wif.work_valid & ready_q;
  assign active     = (state == RUN) || (state == DRAIN);
  assign busy       = (state != IDLE);
  assign core_reset = {NUM_CORES{!active}};
  assign wif.work_ready = ready_q;

  // Next state, shared RUN/DRAIN counter and the completion pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exh_nxt   = 1'b0;
    case (state)
      IDLE:  if (hs) state_nxt = LOAD;
      LOAD: begin
        state_nxt = abort ? IDLE : RUN;
        cnt_nxt   = '0;
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RUN_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else cnt_nxt = cnt + CW'(1);
      end
      DRAIN: begin
        if (abort || cnt == DRAIN_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          exh_nxt   = !abort;
        end else cnt_nxt = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; work_ready is registered so it only tracks the state.
  always_ff @(posedge hash_clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready_q   <= (state_nxt == IDLE);
      exhausted <= exh_nxt;
    end
  end

  // Latch the job and give each core an equal, wrapping nonce slice.
  always_ff @(posedge hash_clk) begin
    if (!reset) begin
      core_midstate  <= '0;
      core_work_data <= '0;
      core_nonce_min <= '0;
    end else if (hs) begin
      core_midstate  <= wif.work_midstate;
      core_work_data <= wif.work_data;
      for (int i = 0; i < NUM_CORES; i++)
        core_nonce_min[i] <= wif.work_nonce_base + (32'(i) << SPAN_LOG2);
    end
  end

  logic [NUM_CORES-1:0]       pending, grant, drop;
  logic [NUM_CORES-1:0][31:0] hold;
  logic [PW-1:0]              ptr, gnt_idx;
  logic                       gnt_vld, full, empty, pop;
  logic [AW:0]                wp, rp;
  res_t                       mem [FIFO_DEPTH];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_cap
    assign grant[i] = gnt_vld && (gnt_idx == PW'(i));
    mws_core_capture u_cap (
      .clk     (hash_clk),
      .reset   (reset),
      .active  (active),
      .pulse   (core_golden_valid[i]),
      .nonce   (core_golden_nonce[i]),
      .grant   (grant[i]),
      .pending (pending[i]),
      .hold    (hold[i]),
      .drop    (drop[i])
    );
  end

  assign full  = (wp - rp) == (AW + 1)'(FIFO_DEPTH);
  assign empty = (wp == rp);
  assign pop   = !empty && wif.res_ready;

  // Round-robin: first pending core at or after the pointer, only with FIFO room.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!gnt_vld && !full && pending[(int'(ptr) + k) % NUM_CORES]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr) + k) % NUM_CORES);
      end
    end
  end

  // FIFO pointers and arbiter pointer; a pop never frees room for the same-cycle write.
  always_ff @(posedge hash_clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      ptr <= '0;
    end else begin
      if (gnt_vld) begin
        wp  <= wp + (AW + 1)'(1);
        ptr <= PW'((int'(gnt_idx) + 1) % NUM_CORES);
      end
      if (pop) rp <= rp + (AW + 1)'(1);
    end
  end

  // FIFO storage needs no reset; outputs are masked while empty.
  always_ff @(posedge hash_clk) begin
    if (gnt_vld) mem[wp[AW-1:0]] <= '{core: 3'(gnt_idx), nonce: hold[gnt_idx]};
  end

  assign wif.res_valid = !empty;
  assign wif.res_nonce = empty ? 32'h0 : mem[rp[AW-1:0]].nonce;
  assign wif.res_core  = empty ? 3'h0  : mem[rp[AW-1:0]].core;

  // Sticky record of any golden nonce lost to an occupied slot.
  always_ff @(posedge hash_clk) begin
    if (!reset)       overflow <= 1'b0;
    else if (|drop)   overflow <= 1'b1;
  end
endmodule

// File: tb/tb_miner_work_scheduler.sv
// Scenario bench for miner_work_scheduler; results checked against a queue.
module tb_miner_work_scheduler;
  localparam int NC = 4;

  logic hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  logic                 reset, abort, busy, exhausted, overflow;
  logic [255:0]         core_midstate;
  logic [95:0]          core_work_data;
  logic [NC-1:0][31:0]  core_nonce_min, core_golden_nonce;
  logic [NC-1:0]        core_reset, core_golden_valid;

  miner_work_scheduler_if wif ();

  miner_work_scheduler #(.NUM_CORES(NC), .SPAN_LOG2(4), .DRAIN_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .hash_clk          (hash_clk),
    .reset             (reset),
    .wif               (wif.slave),
    .abort             (abort),
    .core_midstate     (core_midstate),
    .core_work_data    (core_work_data),
    .core_nonce_min    (core_nonce_min),
    .core_reset        (core_reset),
    .core_golden_valid (core_golden_valid),
    .core_golden_nonce (core_golden_nonce),
    .busy              (busy),
    .exhausted         (exhausted),
    .overflow          (overflow)
  );

  typedef struct packed {
    logic [2:0]  core;
    logic [31:0] nonce;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [255:0] MID  = 256'h4719F6A2_0C3B5E11_8D2A7746_C1E0935B_2F6D88A4_B03C17E9_5A6E0D42_7C1B9A33;
  localparam logic [95:0]  DATA = 96'h1A2B3C4D_5E6F7081_92A3B4C5;

  // Offer one job at a negedge; returns at the negedge inside LOAD.
  task automatic start_job(input logic [31:0] base);
    wif.work_valid      = 1'b1;
    wif.work_midstate   = MID;
    wif.work_data       = DATA;
    wif.work_nonce_base = base;
    @(negedge hash_clk);
    wif.work_valid = 1'b0;
  endtask

  task automatic pulse(input logic [NC-1:0] v, input logic [NC-1:0][31:0] n);
    core_golden_valid = v;
    core_golden_nonce = n;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wif.work_valid = 1'b1;
    repeat (5) @(negedge hash_clk);
    n_checks++; if (wif.work_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", wif.work_ready); else n_pass++;
    n_checks++; if (core_reset !== 4'hF) $display("FAIL rst_core_reset: got %h want f", core_reset); else n_pass++;
    n_checks++; if (core_midstate !== '0 || core_work_data !== '0 || core_nonce_min !== '0)
      $display("FAIL rst_job_regs: got mid=%h min=%h want 0", core_midstate, core_nonce_min); else n_pass++;
    n_checks++; if ({wif.res_valid, wif.res_nonce, wif.res_core} !== '0)
      $display("FAIL rst_res: got v=%b n=%h c=%0d want 0", wif.res_valid, wif.res_nonce, wif.res_core); else n_pass++;
    n_checks++; if ({busy, exhausted, overflow} !== 3'b000)
      $display("FAIL rst_status: got %b want 000", {busy, exhausted, overflow}); else n_pass++;
    wif.work_valid = 1'b0;
    reset = 1'b1;
    @(negedge hash_clk);
    n_checks++; if (wif.work_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_release: got ready=%b busy=%b want 1 0", wif.work_ready, busy); else n_pass++;
  endtask

  task automatic test_normal_job();
    int low_cnt = 0, first_low = -1, exh_cnt = 0, exh_k = -1;
    logic rdy_at = 1'b0, busy_at = 1'b1;
    logic [NC-1:0][31:0] exp_min;
    exp_min = {32'h1DAC2BAA, 32'h1DAC2B9A, 32'h1DAC2B8A, 32'h1DAC2B7A};
    start_job(32'h1DAC2B7A);
    n_checks++; if (core_nonce_min !== exp_min) $display("FAIL normal_min: got %h want %h", core_nonce_min, exp_min); else n_pass++;
    n_checks++; if (core_reset !== 4'hF || busy !== 1'b1)
      $display("FAIL normal_load: got rst=%h busy=%b want f 1", core_reset, busy); else n_pass++;
    for (int k = 1; k <= 30; k++) begin
      if (core_reset == 4'h0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      if (exhausted) begin
        exh_cnt++;
        exh_k   = k;
        rdy_at  = wif.work_ready;
        busy_at = busy;
      end
      @(negedge hash_clk);
    end
    n_checks++; if (low_cnt != 24 || first_low != 2)
      $display("FAIL normal_run_window: got len=%0d start=%0d want 24 2", low_cnt, first_low); else n_pass++;
    n_checks++; if (exh_cnt != 1 || exh_k != 26)
      $display("FAIL normal_exhausted: got count=%0d at=%0d want 1 26", exh_cnt, exh_k); else n_pass++;
    n_checks++; if (rdy_at !== 1'b1 || busy_at !== 1'b0)
      $display("FAIL normal_end_state: got ready=%b busy=%b want 1 0", rdy_at, busy_at); else n_pass++;
    n_checks++; if (core_midstate !== MID || core_work_data !== DATA)
      $display("FAIL normal_latch: got %h %h want %h %h", core_midstate, core_work_data, MID, DATA); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [NC-1:0][31:0] exp_min;
    exp_min = {32'h00000028, 32'h00000018, 32'h00000008, 32'hFFFFFFF8};
    start_job(32'hFFFFFFF8);
    n_checks++; if (core_nonce_min !== exp_min) $display("FAIL wrap_min: got %h want %h", core_nonce_min, exp_min); else n_pass++;
    for (int c = 0; c < 40 && busy; c++) @(negedge hash_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL wrap_done: got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    wif.res_ready = 1'b1;
    start_job(32'h0);
    repeat (2) @(negedge hash_clk);
    pulse(4'b1101, {32'h33, 32'h22, 32'h0, 32'h11});
    sb.push_back('{3'd0, 32'h11}); sb.push_back('{3'd2, 32'h22}); sb.push_back('{3'd3, 32'h33});
    @(negedge hash_clk);
    pulse('0, '0);
    n_checks++; if (wif.res_valid !== 1'b0) $display("FAIL sim_early: got res_valid=%b want 0", wif.res_valid); else n_pass++;
    @(negedge hash_clk);
    n_checks++; if (wif.res_valid !== 1'b1) $display("FAIL sim_latency: got res_valid=%b want 1", wif.res_valid); else n_pass++;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (wif.res_valid) begin
        e = sb.pop_front();
        n_checks++; if (wif.res_core !== e.core || wif.res_nonce !== e.nonce)
          $display("FAIL sim_result: got {%0d,%h} want {%0d,%h}", wif.res_core, wif.res_nonce, e.core, e.nonce); else n_pass++;
      end
      @(negedge hash_clk);
    end
    n_checks++; if (sb.size() != 0) $display("FAIL sim_timeout: got %0d left want 0", sb.size()); else n_pass++;
    // pointer back at 0 means core 0 wins over core 1
    pulse(4'b0011, {32'h0, 32'h0, 32'hB1, 32'hA0});
    sb.push_back('{3'd0, 32'hA0}); sb.push_back('{3'd1, 32'hB1});
    @(negedge hash_clk);
    pulse('0, '0);
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (wif.res_valid) begin
        e = sb.pop_front();
        n_checks++; if (wif.res_core !== e.core || wif.res_nonce !== e.nonce)
          $display("FAIL sim_pointer: got {%0d,%h} want {%0d,%h}", wif.res_core, wif.res_nonce, e.core, e.nonce); else n_pass++;
      end
      @(negedge hash_clk);
    end
    n_checks++; if (sb.size() != 0 || wif.res_valid !== 1'b0)
      $display("FAIL sim_empty: got left=%0d valid=%b want 0 0", sb.size(), wif.res_valid); else n_pass++;
    for (int c = 0; c < 40 && busy; c++) @(negedge hash_clk);
  endtask

  task automatic test_full_overflow();
    exp_t e;
    int   extra = 0;
    logic [NC-1:0][31:0] n;
    wif.res_ready = 1'b0;
    start_job(32'h0);
    repeat (2) @(negedge hash_clk);
    for (int i = 0; i < 5; i++) begin
      n = '0;
      n[i % 4] = 32'h100 + 32'(i);
      pulse(NC'(1) << (i % 4), n);
      sb.push_back('{3'(i % 4), 32'h100 + 32'(i)});
      @(negedge hash_clk);
    end
    pulse('0, '0);
    repeat (2) @(negedge hash_clk);
    n_checks++; if (wif.res_valid !== 1'b1 || overflow !== 1'b0)
      $display("FAIL full_state: got valid=%b ovf=%b want 1 0", wif.res_valid, overflow); else n_pass++;
    n = '0; n[0] = 32'hDEAD;
    pulse(4'b0001, n);
    @(negedge hash_clk);
    pulse('0, '0);
    n_checks++; if (overflow !== 1'b1) $display("FAIL full_overflow: got %b want 1", overflow); else n_pass++;
    wif.res_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (wif.res_valid) begin
        e = sb.pop_front();
        n_checks++; if (wif.res_core !== e.core || wif.res_nonce !== e.nonce)
          $display("FAIL full_result: got {%0d,%h} want {%0d,%h}", wif.res_core, wif.res_nonce, e.core, e.nonce); else n_pass++;
      end
      @(negedge hash_clk);
    end
    n_checks++; if (sb.size() != 0) $display("FAIL full_timeout: got %0d left want 0", sb.size()); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (wif.res_valid) extra++;
      @(negedge hash_clk);
    end
    n_checks++; if (extra != 0) $display("FAIL full_dropped_seen: got %0d extra want 0", extra); else n_pass++;
    for (int c = 0; c < 40 && busy; c++) @(negedge hash_clk);
  endtask

  task automatic test_abort();
    exp_t e;
    int   exh_seen = 0, extra = 0;
    logic [NC-1:0][31:0] n;
    wif.res_ready = 1'b0;
    start_job(32'h0);
    repeat (2) @(negedge hash_clk);
    n = '0; n[1] = 32'h55;
    pulse(4'b0010, n);
    sb.push_back('{3'd1, 32'h55});
    @(negedge hash_clk);
    pulse('0, '0);
    repeat (3) @(negedge hash_clk);
    abort = 1'b1;          // RUN, counter = 5
    @(negedge hash_clk);
    abort = 1'b0;
    n_checks++; if (core_reset !== 4'hF || busy !== 1'b0 || wif.work_ready !== 1'b1 || exhausted !== 1'b0)
      $display("FAIL abort_state: got rst=%h busy=%b ready=%b exh=%b want f 0 1 0",
               core_reset, busy, wif.work_ready, exhausted); else n_pass++;
    n = '0; n[2] = 32'h77;
    pulse(4'b0100, n);
    @(negedge hash_clk);
    pulse('0, '0);
    for (int c = 0; c < 10; c++) begin
      if (exhausted) exh_seen++;
      @(negedge hash_clk);
    end
    n_checks++; if (exh_seen != 0) $display("FAIL abort_no_exhausted: got %0d pulses want 0", exh_seen); else n_pass++;
    n_checks++; if (wif.res_valid !== 1'b1) $display("FAIL abort_fifo_kept: got valid=%b want 1", wif.res_valid); else n_pass++;
    wif.res_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (wif.res_valid) begin
        e = sb.pop_front();
        n_checks++; if (wif.res_core !== e.core || wif.res_nonce !== e.nonce)
          $display("FAIL abort_result: got {%0d,%h} want {%0d,%h}", wif.res_core, wif.res_nonce, e.core, e.nonce); else n_pass++;
      end
      @(negedge hash_clk);
    end
    n_checks++; if (sb.size() != 0) $display("FAIL abort_timeout: got %0d left want 0", sb.size()); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (wif.res_valid) extra++;
      @(negedge hash_clk);
    end
    n_checks++; if (extra != 0) $display("FAIL abort_idle_pulse: got %0d extra want 0", extra); else n_pass++;
  endtask

  initial begin
    abort = 1'b0;
    core_golden_valid = '0;
    core_golden_nonce = '0;
    wif.work_midstate = '0;
    wif.work_data = '0;
    wif.work_nonce_base = '0;
    wif.res_ready = 1'b0;
    test_reset();
    test_normal_job();
    test_wrap();
    test_simultaneous();
    test_full_overflow();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
